if_stage_fetch: RTL
===================

Name: if_stage_fetch

Overview:
- Instruction-fetch stage (pre-IF plus IF) of the 5-stage in-order LoongArch pipeline.
- Generates the next PC, drives the synchronous inst SRAM port, and holds the returned instruction across decode stalls in a one-entry buffer.
- Hands {inst, pc} to the decode stage with a valid/allowin handshake.
- Applies branch redirects issued by decode, discarding the wrong-path instruction.

Parameters:
- RESET_PC, 32'h1c000000, address of the first instruction fetched after reset.

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge.
- resetn  input  1  reset, asynchronous, active-low.
- ds_allowin  input  1  decode can accept an instruction this cycle.
- br_taken  input  1  single-cycle redirect pulse from decode.
- br_target  input  32  redirect address, valid while br_taken=1.
- fs_to_ds_valid  output  1  fs_to_ds_bus holds a valid instruction.
- fs_to_ds_bus  output  64  {inst[63:32], pc[31:0]}.
- inst_sram_en  output  1  SRAM read enable.
- inst_sram_we  output  4  always 4'b0000.
- inst_sram_addr  output  32  fetch address (= nextpc).
- inst_sram_wdata  output  32  always 32'h0.
- inst_sram_rdata  input  32  read data, one cycle after an enabled request.
- fetch_count  output  32  number of instructions accepted by decode.

Behaviour:
- State: fs_valid, fs_pc[31:0], inst_buf[31:0], inst_buf_valid, fetch_count[31:0].
- Reset (resetn=0, asynchronous):
  - fs_valid=0, fs_pc=RESET_PC-4, inst_buf_valid=0, inst_buf=0, fetch_count=0.
  - inst_sram_en is forced to 0 combinationally.
  - Outputs during reset: fs_to_ds_valid=0, fs_to_ds_bus={inst_sram_rdata, RESET_PC-4}.
- Combinational terms:
  - fs_ready_go=1.
  - fs_allowin = !fs_valid | ds_allowin.
  - seq_pc = fs_pc + 4 (32-bit, wraps modulo 2^32).
  - nextpc = br_taken ? br_target : seq_pc.
  - inst_sram_addr = nextpc; low two bits are passed unmodified (no alignment check in this block).
  - inst_sram_en = resetn & (fs_allowin | br_taken).
  - fs_inst = inst_buf_valid ? inst_buf : inst_sram_rdata.
  - fs_to_ds_valid = fs_valid & !br_taken.
  - fs_to_ds_bus = {fs_inst, fs_pc}.
- Handshake: a transfer occurs when fs_to_ds_valid & ds_allowin.
  - fetch_count increments by 1 per transfer and wraps at 2^32.
  - The bus must stay stable while fs_to_ds_valid=1 and ds_allowin=0.
- Advance: when inst_sram_en=1 on an edge, fs_pc<=nextpc and fs_valid<=1. The SRAM data for nextpc appears on inst_sram_rdata in the following cycle.
- Stall capture:
  - Condition: fs_valid & !ds_allowin & !inst_buf_valid & !br_taken.
  - Action: inst_buf<=inst_sram_rdata, inst_buf_valid<=1. SRAM output is not guaranteed stable after the request cycle, so the buffer must be used.
  - inst_buf_valid clears on a transfer or on br_taken.
- Redirect (br_taken=1):
  - The current IF instruction is squashed; fs_to_ds_valid=0 in that cycle.
  - br_target is fetched in the same cycle regardless of ds_allowin.
  - Next cycle: fs_pc=br_target, fs_valid=1.
  - br_taken with fs_valid=0 behaves identically.
- Simultaneous events: br_taken takes priority over stall capture and sequential advance.
- Throughput: 1 instruction per cycle with no stalls.
- Latency: reset release to first fs_to_ds_valid = 1 cycle.

Test Plan:
- Reset release, ds_allowin=1: cycle 0 has en=1, addr=32'h1c000000. Cycle 1 has valid=1, pc=32'h1c000000, inst=SRAM[0]. Cycle 2 has pc=32'h1c000004. fetch_count increments every cycle.
- ds_allowin=0 for 3 cycles while pc=32'h1c000008: bus stays {SRAM word 2, 32'h1c000008} throughout, even if rdata is corrupted to 32'hdeadbeef, and inst_sram_en=0. On ds_allowin=1: transfer occurs, then pc=32'h1c00000c.
- br_taken with br_target=32'h1c000100 while pc=32'h1c000010 is in IF: no transfer of 32'h1c000010. Next cycle pc=32'h1c000100 with its SRAM word. fetch_count is not incremented for the squashed instruction.
- br_taken coincident with ds_allowin=0 and inst_buf_valid=1: buffer cleared, addr=br_target that cycle. Next cycle shows the target instruction, not the buffered one.
- Assert resetn=0 asynchronously mid-stream at pc=32'h1c000020: fs_to_ds_valid=0 and inst_sram_en=0 immediately, before the next edge. Re-release restarts at 32'h1c000000 with fetch_count=0.
- br_target=32'hfffffffc then continuous fetch: next pc wraps to 32'h00000000.

Source files
------------

// File: rtl/if_stage_fetch_if.sv
// Fetch-stage boundary: decode handshake, redirect inputs, inst SRAM port and counter.
// The master side belongs to the fetch stage and the slave side to its environment.
interface if_stage_fetch_if;
    logic        ds_allowin;
    logic        br_taken;
    logic [31:0] br_target;
    logic        fs_to_ds_valid;
    logic [63:0] fs_to_ds_bus;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_we;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;
    logic [31:0] fetch_count;

    modport master (
        input  ds_allowin,
        input  br_taken,
        input  br_target,
        input  inst_sram_rdata,
        output fs_to_ds_valid,
        output fs_to_ds_bus,
        output inst_sram_en,
        output inst_sram_we,
        output inst_sram_addr,
        output inst_sram_wdata,
        output fetch_count
    );

    modport slave (
        output ds_allowin,
        output br_taken,
        output br_target,
        output inst_sram_rdata,
        input  fs_to_ds_valid,
        input  fs_to_ds_bus,
        input  inst_sram_en,
        input  inst_sram_we,
        input  inst_sram_addr,
        input  inst_sram_wdata,
        input  fetch_count
    );
endinterface

// File: rtl/if_stage_fetch.sv
// Pre-IF/IF stage: next-PC selection, inst SRAM request, one-entry stall buffer
// and decode handshake, with decode-issued branch redirects squashing the IF slot.
module if_stage_fetch #(
    parameter logic [31:0] RESET_PC = 32'h1c00_0000
) (
    input  logic             clk,
    input  logic             resetn,
    if_stage_fetch_if.master fs
);

    logic        fs_valid_q,       fs_valid_d;
    logic [31:0] fs_pc_q,          fs_pc_d;
    logic [31:0] inst_buf_q,       inst_buf_d;
    logic        inst_buf_valid_q, inst_buf_valid_d;
    logic [31:0] fetch_count_q,    fetch_count_d;

    logic        fs_ready_go_s;
    logic        fs_allowin_s;
    logic [31:0] seq_pc_s;
    logic [31:0] nextpc_s;
    logic        sram_en_s;
    logic [31:0] fs_inst_s;
    logic        to_ds_valid_s;
    logic        xfer_s;
    logic        capture_s;

    // Datapath terms: next PC, SRAM enable, instruction source and handshake.
    always_comb begin
        fs_ready_go_s = 1'b1;
        fs_allowin_s  = !fs_valid_q | (fs_ready_go_s & fs.ds_allowin);
        seq_pc_s      = fs_pc_q + 32'd4;
        nextpc_s      = seq_pc_s;
        fs_inst_s     = fs.inst_sram_rdata;
        if (fs.br_taken) begin
            nextpc_s = fs.br_target;
        end else begin
            nextpc_s = seq_pc_s;
        end
        // The SRAM only holds its data for one cycle, so a stalled word lives in inst_buf.
        if (inst_buf_valid_q) begin
            fs_inst_s = inst_buf_q;
        end else begin
            fs_inst_s = fs.inst_sram_rdata;
        end
        sram_en_s     = resetn & (fs_allowin_s | fs.br_taken);
        to_ds_valid_s = fs_valid_q & fs_ready_go_s & !fs.br_taken;
        xfer_s        = to_ds_valid_s & fs.ds_allowin;
        capture_s     = fs_valid_q & !fs.ds_allowin & !inst_buf_valid_q & !fs.br_taken;
    end

    // Next-state: PC advance, stall buffer fill/flush, accepted-instruction count.
    always_comb begin
        fs_valid_d       = fs_valid_q;
        fs_pc_d          = fs_pc_q;
        inst_buf_d       = inst_buf_q;
        inst_buf_valid_d = inst_buf_valid_q;
        fetch_count_d    = fetch_count_q;

        if (sram_en_s) begin
            fs_valid_d = 1'b1;
            fs_pc_d    = nextpc_s;
        end else begin
            fs_valid_d = fs_valid_q;
            fs_pc_d    = fs_pc_q;
        end

        // A redirect outranks both the flush-on-transfer and the stall capture.
        if (fs.br_taken) begin
            inst_buf_valid_d = 1'b0;
        end else if (xfer_s) begin
            inst_buf_valid_d = 1'b0;
        end else if (capture_s) begin
            inst_buf_valid_d = 1'b1;
            inst_buf_d       = fs.inst_sram_rdata;
        end else begin
            inst_buf_valid_d = inst_buf_valid_q;
        end

        if (xfer_s) begin
            fetch_count_d = fetch_count_q + 32'd1;
        end else begin
            fetch_count_d = fetch_count_q;
        end
    end

    // Stage state registers; reset parks the PC one word before the boot address.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fs_valid_q       <= 1'b0;
            fs_pc_q          <= RESET_PC - 32'd4;
            inst_buf_q       <= 32'h0000_0000;
            inst_buf_valid_q <= 1'b0;
            fetch_count_q    <= 32'h0000_0000;
        end else begin
            fs_valid_q       <= fs_valid_d;
            fs_pc_q          <= fs_pc_d;
            inst_buf_q       <= inst_buf_d;
            inst_buf_valid_q <= inst_buf_valid_d;
            fetch_count_q    <= fetch_count_d;
        end
    end

    assign fs.fs_to_ds_valid  = to_ds_valid_s;
    assign fs.fs_to_ds_bus    = {fs_inst_s, fs_pc_q};
    assign fs.inst_sram_en    = sram_en_s;
    assign fs.inst_sram_we    = 4'b0000;
    assign fs.inst_sram_addr  = nextpc_s;
    assign fs.inst_sram_wdata = 32'h0000_0000;
    assign fs.fetch_count     = fetch_count_q;

endmodule
